// File: rtl/drac_pkg.sv
// Shared CSR interface types and the commit-side CSR sequencer state encoding.
package drac_pkg;

  typedef logic [63:0] bus64_t;

  typedef enum logic [2:0] {
    CSR_CMD_NOPE  = 3'd0,
    CSR_CMD_WRITE = 3'd1,
    CSR_CMD_SET   = 3'd2,
    CSR_CMD_CLEAR = 3'd3,
    CSR_CMD_READ  = 3'd4
  } csr_cmd_t;

  typedef struct packed {
    logic [11:0] csr_rw_addr;
    csr_cmd_t    csr_rw_cmd;
    bus64_t      csr_rw_data;
    logic [1:0]  csr_retire;
    logic        csr_xcpt;
    bus64_t      csr_xcpt_cause;
    bus64_t      csr_pc;
  } req_cpu_csr_t;

  typedef struct packed {
    bus64_t csr_rw_rdata;
    logic   csr_replay;
    logic   csr_exception;
  } resp_csr_cpu_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    BACKOFF,
    DONE
  } csr_seq_state_t;

endpackage

// File: rtl/csr_commit_seq.sv
// Sequences one commit-side CSR access at a time: issue, wait, replay with backoff,
// then report completion (rdata/exception) back to commit.
module csr_commit_seq
  import drac_pkg::*;
#(
  parameter int unsigned MAX_REPLAY   = 4,
  parameter int unsigned REPLAY_DELAY = 2,
  parameter int unsigned RESP_TIMEOUT = 64
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          flush_i,
  input  logic          csr_ena_int_i,
  input  req_cpu_csr_t  req_cpu_csr_i,
  output req_cpu_csr_t  req_cpu_csr_o,
  output logic          csr_req_valid_o,
  input  logic          csr_req_ready_i,
  input  logic          resp_valid_i,
  input  resp_csr_cpu_t resp_csr_cpu_i,
  output logic          commit_stall_o,
  output bus64_t        csr_rdata_o,
  output logic          csr_done_o,
  output logic          csr_xcpt_o,
  output logic          replay_limit_o,
  output logic          timeout_o
);

  localparam int unsigned RCW = $clog2(MAX_REPLAY + 1);
  localparam int unsigned TW  = $clog2(RESP_TIMEOUT);
  localparam logic [RCW-1:0] REPLAY_MAX   = RCW'(MAX_REPLAY);
  localparam logic [TW-1:0]  TIMER_LAST   = TW'(RESP_TIMEOUT - 1);
  localparam logic [TW-1:0]  BACKOFF_LAST = TW'(REPLAY_DELAY - 1);

  csr_seq_state_t state_q, state_d;
  req_cpu_csr_t   req_q, req_d, issue_req;
  logic [RCW-1:0] replay_cnt_q, replay_cnt_d;
  logic [TW-1:0]  timer_q, timer_d, timer_inc;
  bus64_t         rdata_q, rdata_d;
  logic           xcpt_q, xcpt_d;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      req_q        <= '0;
      replay_cnt_q <= '0;
      timer_q      <= '0;
      rdata_q      <= '0;
      xcpt_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      replay_cnt_q <= replay_cnt_d;
      timer_q      <= timer_d;
      rdata_q      <= rdata_d;
      xcpt_q       <= xcpt_d;
    end
  end

  assign csr_rdata_o = rdata_q;
  assign timer_inc   = (timer_q == '1) ? timer_q : timer_q + TW'(1);

  always_comb begin
    state_d         = state_q;
    req_d           = req_q;
    replay_cnt_d    = replay_cnt_q;
    timer_d         = timer_q;
    rdata_d         = rdata_q;
    xcpt_d          = xcpt_q;
    req_cpu_csr_o   = '0;
    csr_req_valid_o = 1'b0;
    commit_stall_o  = 1'b0;
    csr_done_o      = 1'b0;
    csr_xcpt_o      = 1'b0;
    replay_limit_o  = 1'b0;
    timeout_o       = 1'b0;
    // Retirement is only ever reported from DONE.
    issue_req            = req_q;
    issue_req.csr_retire = 2'b00;

    unique case (state_q)
      IDLE: begin
        req_cpu_csr_o = req_cpu_csr_i;
        replay_cnt_d  = '0;
        timer_d       = '0;
        if (csr_ena_int_i && !flush_i) begin
          req_cpu_csr_o  = '0;
          commit_stall_o = 1'b1;
          req_d          = req_cpu_csr_i;
          state_d        = ISSUE;
        end
      end
      ISSUE: begin
        req_cpu_csr_o   = issue_req;
        csr_req_valid_o = 1'b1;
        commit_stall_o  = 1'b1;
        if (csr_req_ready_i) begin
          timer_d = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        req_cpu_csr_o  = issue_req;
        commit_stall_o = 1'b1;
        timer_d        = timer_inc;
        if (resp_valid_i) begin
          if (!resp_csr_cpu_i.csr_replay) begin
            rdata_d = resp_csr_cpu_i.csr_rw_rdata;
            xcpt_d  = resp_csr_cpu_i.csr_exception;
            state_d = DONE;
          end else begin
            replay_cnt_d = (replay_cnt_q == REPLAY_MAX) ? replay_cnt_q
                                                        : replay_cnt_q + RCW'(1);
            if (replay_cnt_q < REPLAY_MAX) begin
              timer_d = '0;
              state_d = BACKOFF;
            end else begin
              replay_limit_o = 1'b1;
              state_d        = IDLE;
            end
          end
        end else if (timer_q == TIMER_LAST) begin
          timeout_o = 1'b1;
          state_d   = IDLE;
        end
      end
      BACKOFF: begin
        req_cpu_csr_o  = issue_req;
        commit_stall_o = 1'b1;
        if (timer_q == BACKOFF_LAST) begin
          timer_d = '0;
          state_d = ISSUE;
        end else begin
          timer_d = timer_inc;
        end
      end
      DONE: begin
        req_cpu_csr_o            = req_q;
        req_cpu_csr_o.csr_retire = 2'b01;
        req_cpu_csr_o.csr_rw_cmd = CSR_CMD_NOPE;
        csr_done_o               = 1'b1;
        csr_xcpt_o               = xcpt_q;
        state_d                  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A flush kills the access outright: nothing completes, nothing is captured.
    if (flush_i) begin
      state_d        = IDLE;
      replay_cnt_d   = '0;
      timer_d        = '0;
      rdata_d        = rdata_q;
      xcpt_d         = xcpt_q;
      csr_done_o     = 1'b0;
      csr_xcpt_o     = 1'b0;
      replay_limit_o = 1'b0;
      timeout_o      = 1'b0;
      if (state_q == DONE) req_cpu_csr_o = '0;
    end

    // Keep the bypass path quiet while reset is asserted.
    if (!rstn_i) begin
      req_cpu_csr_o   = '0;
      csr_req_valid_o = 1'b0;
      commit_stall_o  = 1'b0;
      csr_done_o      = 1'b0;
      csr_xcpt_o      = 1'b0;
      replay_limit_o  = 1'b0;
      timeout_o       = 1'b0;
    end
  end

endmodule

// File: tb/tb_csr_commit_seq.sv
// Self-checking bench for csr_commit_seq: scenario tasks against a cycle-arithmetic model.
module tb_csr_commit_seq;
  import drac_pkg::*;

  localparam int MAX_REPLAY   = 4;
  localparam int REPLAY_DELAY = 2;
  localparam int RESP_TIMEOUT = 64;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          flush = 1'b0;
  logic          ena = 1'b0;
  req_cpu_csr_t  req_i = '0;
  req_cpu_csr_t  req_o;
  logic          valid;
  logic          ready = 1'b0;
  logic          resp_valid = 1'b0;
  resp_csr_cpu_t resp = '0;
  logic          stall;
  bus64_t        rdata;
  logic          done, xcpt, limit, tmo;

  int errors = 0;
  int checks = 0;
  bus64_t model_rdata = '0;

  csr_commit_seq #(
    .MAX_REPLAY  (MAX_REPLAY),
    .REPLAY_DELAY(REPLAY_DELAY),
    .RESP_TIMEOUT(RESP_TIMEOUT)
  ) dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .flush_i        (flush),
    .csr_ena_int_i  (ena),
    .req_cpu_csr_i  (req_i),
    .req_cpu_csr_o  (req_o),
    .csr_req_valid_o(valid),
    .csr_req_ready_i(ready),
    .resp_valid_i   (resp_valid),
    .resp_csr_cpu_i (resp),
    .commit_stall_o (stall),
    .csr_rdata_o    (rdata),
    .csr_done_o     (done),
    .csr_xcpt_o     (xcpt),
    .replay_limit_o (limit),
    .timeout_o      (tmo)
  );

  always #5 clk = ~clk;

  // Passive monitor: event counters sampled on the falling edge.
  int cyc = 0;
  int m_issue = 0, m_done = 0, m_xcpt = 0, m_limit = 0, m_tmo = 0, m_stall = 0;
  int m_valid = 0, m_unstable = 0, m_retire = 0, m_proto = 0, m_done_cyc = 0, m_limit_cyc = 0;
  req_cpu_csr_t m_issue_req = '0, prev_req = '0;
  logic prev_vnr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rstn) begin
      if (valid && ready) begin
        m_issue     <= m_issue + 1;
        m_issue_req <= req_o;
      end
      if (valid) m_valid <= m_valid + 1;
      if (stall) m_stall <= m_stall + 1;
      if (done) begin
        m_done     <= m_done + 1;
        m_done_cyc <= cyc;
      end
      if (xcpt) m_xcpt <= m_xcpt + 1;
      if ((done && req_o.csr_rw_cmd != CSR_CMD_NOPE) || (xcpt && !done)) m_proto <= m_proto + 1;
      if (limit) begin
        m_limit     <= m_limit + 1;
        m_limit_cyc <= cyc;
      end
      if (tmo) m_tmo <= m_tmo + 1;
      if (req_o.csr_retire == 2'b01) m_retire <= m_retire + 1;
      if (prev_vnr && (!valid || req_o != prev_req)) m_unstable <= m_unstable + 1;
      prev_vnr <= valid && !ready;
      prev_req <= req_o;
    end else begin
      prev_vnr <= 1'b0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic req_cpu_csr_t rand_req(input logic keep_retire);
    req_cpu_csr_t r;
    r.csr_rw_addr    = 12'($urandom);
    r.csr_rw_cmd     = csr_cmd_t'(3'($urandom_range(1, 4)));
    r.csr_rw_data    = {$urandom, $urandom};
    r.csr_retire     = keep_retire ? 2'($urandom) : 2'b00;
    r.csr_xcpt       = 1'($urandom);
    r.csr_xcpt_cause = {$urandom, $urandom};
    r.csr_pc         = {$urandom, $urandom};
    return r;
  endfunction

  // Reference timing: cycle of the last response seen by the access.
  function automatic int model_last_resp(input int lc, input int rd, input int rsp,
                                         input int nrep);
    int na = (nrep > MAX_REPLAY) ? MAX_REPLAY + 1 : nrep + 1;
    int s  = lc + 1;
    int r  = 0;
    for (int a = 0; a < na; a++) begin
      if (a > 0) s = r + 1 + REPLAY_DELAY;
      r = s + rd + 1 + rsp;
    end
    return r;
  endfunction

  task automatic drive_access(input req_cpu_csr_t rq, input int rd, input int rsp,
                              input int nrep, input bus64_t rdat, input logic xc,
                              output int lc);
    int na = (nrep > MAX_REPLAY) ? MAX_REPLAY + 1 : nrep + 1;
    lc    = cyc;
    ena   = 1'b1;
    req_i = rq;
    tick();
    ena   = 1'b0;
    req_i = rand_req(1'b0);
    for (int a = 0; a < na; a++) begin
      if (a > 0) repeat (REPLAY_DELAY) tick();
      repeat (rd) tick();
      ready = 1'b1;
      tick();
      ready = 1'b0;
      repeat (rsp) tick();
      resp_valid             = 1'b1;
      resp.csr_replay        = (a < nrep);
      resp.csr_rw_rdata      = (a < nrep) ? {$urandom, $urandom} : rdat;
      resp.csr_exception     = xc;
      tick();
      resp_valid = 1'b0;
    end
    repeat (3) tick();
  endtask

  task automatic test_reset;
    ena   = 1'b1;
    req_i = rand_req(1'b1);
    #1;
    checks++;
    if (req_o !== '0 || valid !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: req=%0h valid=%b stall=%b required all zero", req_o, valid, stall);
    end
    checks++;
    if ({done, xcpt, limit, tmo} !== 4'b0 || rdata !== '0) begin
      errors++;
      $display("FAIL reset_pulses: pulses=%b rdata=%0h required 0", {done, xcpt, limit, tmo}, rdata);
    end
    tick();
    ena  = 1'b0;
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_bypass;
    for (int i = 0; i < 4; i++) begin
      req_i = rand_req(1'b1);
      @(negedge clk);
      checks++;
      if (req_o !== req_i || valid !== 1'b0 || stall !== 1'b0) begin
        errors++;
        $display("FAIL bypass_%0d: req=%0h valid=%b stall=%b required req=%0h valid=0 stall=0",
                 i, req_o, valid, stall, req_i);
      end
      tick();
    end
    req_i = rand_req(1'b0);
  endtask

  task automatic test_basic;
    req_cpu_csr_t rq = rand_req(1'b1);
    req_cpu_csr_t exp_req;
    int lc;
    int r0 = m_retire, d0 = m_done;
    rq.csr_rw_addr = 12'h300;
    rq.csr_rw_cmd  = CSR_CMD_WRITE;
    rq.csr_rw_data = 64'h8;
    exp_req = rq;
    exp_req.csr_retire = 2'b00;
    drive_access(rq, 0, 1, 0, 64'h1800, 1'b0, lc);
    model_rdata = 64'h1800;
    checks++;
    if (m_done - d0 !== 1 || m_done_cyc !== lc + 4) begin
      errors++;
      $display("FAIL basic_done: count=%0d cycle=%0d required 1 at %0d", m_done - d0, m_done_cyc, lc + 4);
    end
    checks++;
    if (rdata !== model_rdata) begin
      errors++;
      $display("FAIL basic_rdata: got %0h required %0h", rdata, model_rdata);
    end
    checks++;
    if (m_retire - r0 !== 1) begin
      errors++;
      $display("FAIL basic_retire: got %0d required 1", m_retire - r0);
    end
    checks++;
    if (m_issue_req !== exp_req) begin
      errors++;
      $display("FAIL basic_issue_req: got %0h required %0h", m_issue_req, exp_req);
    end
  endtask

  task automatic test_ready_low;
    int lc;
    int i0 = m_issue, v0 = m_valid, u0 = m_unstable, s0 = m_stall;
    drive_access(rand_req(1'b1), 5, 0, 0, {$urandom, $urandom}, 1'b0, lc);
    model_rdata = resp.csr_rw_rdata;
    checks++;
    if (m_valid - v0 !== 6 || m_issue - i0 !== 1) begin
      errors++;
      $display("FAIL ready_low_issue: valid_cycles=%0d issues=%0d required 6 and 1",
               m_valid - v0, m_issue - i0);
    end
    checks++;
    if (m_unstable - u0 !== 0) begin
      errors++;
      $display("FAIL ready_low_stable: got %0d changes required 0", m_unstable - u0);
    end
    checks++;
    if (m_stall - s0 !== model_last_resp(lc, 5, 0, 0) - lc + 1) begin
      errors++;
      $display("FAIL ready_low_stall: got %0d required %0d", m_stall - s0,
               model_last_resp(lc, 5, 0, 0) - lc + 1);
    end
  endtask

  task automatic test_replay;
    int lc;
    int i0 = m_issue, d0 = m_done;
    bus64_t rd = {$urandom, $urandom};
    drive_access(rand_req(1'b1), 0, 0, 2, rd, 1'b0, lc);
    model_rdata = rd;
    checks++;
    if (m_issue - i0 !== 3 || m_done - d0 !== 1) begin
      errors++;
      $display("FAIL replay_counts: issues=%0d done=%0d required 3 and 1", m_issue - i0, m_done - d0);
    end
    checks++;
    if (m_done_cyc !== model_last_resp(lc, 0, 0, 2) + 1 || rdata !== model_rdata) begin
      errors++;
      $display("FAIL replay_done: cycle=%0d rdata=%0h required %0d and %0h", m_done_cyc, rdata,
               model_last_resp(lc, 0, 0, 2) + 1, model_rdata);
    end
  endtask

  task automatic test_replay_limit;
    int lc;
    int i0 = m_issue, d0 = m_done, l0 = m_limit;
    drive_access(rand_req(1'b1), 1, 1, 5, '0, 1'b0, lc);
    checks++;
    if (m_limit - l0 !== 1 || m_limit_cyc !== model_last_resp(lc, 1, 1, 5)) begin
      errors++;
      $display("FAIL limit_pulse: count=%0d cycle=%0d required 1 at %0d", m_limit - l0, m_limit_cyc,
               model_last_resp(lc, 1, 1, 5));
    end
    checks++;
    if (m_done - d0 !== 0 || m_issue - i0 !== 5) begin
      errors++;
      $display("FAIL limit_counts: done=%0d issues=%0d required 0 and 5", m_done - d0, m_issue - i0);
    end
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || rdata !== model_rdata) begin
      errors++;
      $display("FAIL limit_idle: stall=%b rdata=%0h required 0 and %0h", stall, rdata, model_rdata);
    end
    tick();
  endtask

  task automatic test_timeout;
    int lc = cyc;
    int t0 = m_tmo;
    ena   = 1'b1;
    req_i = rand_req(1'b1);
    tick();
    ena   = 1'b0;
    req_i = rand_req(1'b0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    repeat (RESP_TIMEOUT - 2) tick();
    @(negedge clk);
    checks++;
    if (tmo !== 1'b0 || cyc !== lc + RESP_TIMEOUT) begin
      errors++;
      $display("FAIL timeout_early: tmo=%b at cycle %0d required 0 at %0d", tmo, cyc, lc + RESP_TIMEOUT);
    end
    tick();
    @(negedge clk);
    checks++;
    if (tmo !== 1'b1 || stall !== 1'b1) begin
      errors++;
      $display("FAIL timeout_pulse: tmo=%b stall=%b required 1 and 1", tmo, stall);
    end
    tick();
    @(negedge clk);
    checks++;
    if (tmo !== 1'b0 || stall !== 1'b0 || m_tmo - t0 !== 1) begin
      errors++;
      $display("FAIL timeout_release: tmo=%b stall=%b count=%0d required 0 0 1", tmo, stall, m_tmo - t0);
    end
    tick();
  endtask

  task automatic test_flush;
    int d0 = m_done, x0 = m_xcpt, i0;
    ena   = 1'b1;
    req_i = rand_req(1'b1);
    tick();
    ena   = 1'b0;
    req_i = rand_req(1'b0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    resp_valid = 1'b1;
    resp.csr_replay = 1'b0;
    resp.csr_exception = 1'b1;
    resp.csr_rw_rdata = {$urandom, $urandom};
    flush = 1'b1;
    tick();
    resp_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || valid !== 1'b0 || rdata !== model_rdata) begin
      errors++;
      $display("FAIL flush_wait: stall=%b valid=%b rdata=%0h required 0 0 %0h", stall, valid, rdata, model_rdata);
    end
    tick();
    i0 = m_issue;
    ena   = 1'b1;
    req_i = rand_req(1'b1);
    tick();
    ena   = 1'b0;
    req_i = rand_req(1'b0);
    ready = 1'b1;
    flush = 1'b1;
    tick();
    ready = 1'b0;
    flush = 1'b0;
    resp_valid = 1'b1;
    resp.csr_rw_rdata = {$urandom, $urandom};
    tick();
    resp_valid = 1'b0;
    repeat (2) tick();
    checks++;
    if (m_done - d0 !== 0 || m_xcpt - x0 !== 0 || rdata !== model_rdata) begin
      errors++;
      $display("FAIL flush_dropped: done=%0d xcpt=%0d rdata=%0h required 0 0 %0h",
               m_done - d0, m_xcpt - x0, rdata, model_rdata);
    end
    checks++;
    if (m_issue - i0 !== 1) begin
      errors++;
      $display("FAIL flush_issue: handshakes=%0d required 1", m_issue - i0);
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 8; it++) begin
      req_cpu_csr_t rq = rand_req(1'b1);
      req_cpu_csr_t exp_req;
      int rd = $urandom_range(0, 3), rsp = $urandom_range(0, 4), nrep = $urandom_range(0, 5);
      logic xc = 1'($urandom);
      bus64_t rdat = {$urandom, $urandom};
      int i0 = m_issue, d0 = m_done, x0 = m_xcpt, l0 = m_limit, s0 = m_stall;
      int v0 = m_valid, r0 = m_retire, p0 = m_proto, u0 = m_unstable;
      int lc, last, na, ok;
      drive_access(rq, rd, rsp, nrep, rdat, xc, lc);
      last = model_last_resp(lc, rd, rsp, nrep);
      ok   = (nrep <= MAX_REPLAY) ? 1 : 0;
      na   = ok ? nrep + 1 : MAX_REPLAY + 1;
      if (ok == 1) model_rdata = rdat;
      exp_req = rq;
      exp_req.csr_retire = 2'b00;
      checks++;
      if (m_issue - i0 !== na || m_valid - v0 !== na * (rd + 1)) begin
        errors++;
        $display("FAIL rand%0d_issue: issues=%0d valid=%0d required %0d and %0d", it,
                 m_issue - i0, m_valid - v0, na, na * (rd + 1));
      end
      checks++;
      if (m_done - d0 !== ok || m_limit - l0 !== 1 - ok || m_retire - r0 !== ok) begin
        errors++;
        $display("FAIL rand%0d_outcome: done=%0d limit=%0d retire=%0d required done=%0d", it,
                 m_done - d0, m_limit - l0, m_retire - r0, ok);
      end
      checks++;
      if (m_xcpt - x0 !== ok * int'(xc) || m_proto - p0 !== 0 || m_unstable - u0 !== 0) begin
        errors++;
        $display("FAIL rand%0d_xcpt: xcpt=%0d proto=%0d unstable=%0d required %0d 0 0", it,
                 m_xcpt - x0, m_proto - p0, m_unstable - u0, ok * int'(xc));
      end
      checks++;
      if (m_stall - s0 !== last - lc + 1) begin
        errors++;
        $display("FAIL rand%0d_stall: got %0d required %0d", it, m_stall - s0, last - lc + 1);
      end
      checks++;
      if ((ok == 1 && m_done_cyc !== last + 1) || (ok == 0 && m_limit_cyc !== last)) begin
        errors++;
        $display("FAIL rand%0d_timing: done=%0d limit=%0d required end at %0d", it, m_done_cyc,
                 m_limit_cyc, ok ? last + 1 : last);
      end
      checks++;
      if (rdata !== model_rdata || m_issue_req !== exp_req) begin
        errors++;
        $display("FAIL rand%0d_data: rdata=%0h req=%0h required %0h and %0h", it, rdata,
                 m_issue_req, model_rdata, exp_req);
      end
    end
  endtask

  task automatic test_reset_backoff;
    int d0 = m_done, l0 = m_limit;
    ena   = 1'b1;
    req_i = rand_req(1'b1);
    tick();
    ena   = 1'b0;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    resp_valid = 1'b1;
    resp.csr_replay = 1'b1;
    tick();
    resp_valid = 1'b0;
    ena   = 1'b1;
    req_i = rand_req(1'b1);
    #1;
    checks++;
    if (stall !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL backoff_state: stall=%b valid=%b required 1 and 0", stall, valid);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (req_o !== '0 || {valid, stall, done, xcpt, limit, tmo} !== 6'b0 || rdata !== '0) begin
      errors++;
      $display("FAIL reset_async: req=%0h flags=%b rdata=%0h required all zero", req_o,
               {valid, stall, done, xcpt, limit, tmo}, rdata);
    end
    repeat (2) tick();
    ena  = 1'b0;
    req_i = rand_req(1'b0);
    rstn = 1'b1;
    model_rdata = '0;
    tick();
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || m_done - d0 !== 0 || m_limit - l0 !== 0) begin
      errors++;
      $display("FAIL reset_recover: stall=%b done=%0d limit=%0d required 0 0 0", stall,
               m_done - d0, m_limit - l0);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_basic();
    test_ready_low();
    test_replay();
    test_replay_limit();
    test_timeout();
    test_flush();
    test_random();
    test_reset_backoff();
    test_basic();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
